instr_fetch_unit: RTL and testbench

Program-sequencing block that sits on the other end of the controller's PC/IR strobes. It owns the program counter and instruction register, and executes the controller's LoadIR / IncPC / LoadPC / SelPC commands. It fetches instructions over a req/ack memory port and returns the opcode to the controller, with valid, halt and error status.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/rise_detect.sv | 33 +++
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the program-sequencing blocks: default datapath
// widths, the HALT opcode encoding and the instruction-fetch FSM state type.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 8;

    // Any instruction whose upper nibble matches this stops the sequencer.
    localparam logic [3:0] OPC_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } fetch_state_t;

    function automatic logic is_halt(input logic [3:0] opc_hi);
        return opc_hi == OPC_HALT;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Turns a level command into a single-cycle fire: o_rise is high when i_sig is
// 1 now and was 0 on the previous clock. History clears on reset, so a level
// held through reset fires on the first cycle after reset.
//   clk     in   clock
//   reset   in   synchronous, active-high
//   i_sig   in   level command
//   o_rise  out  rising-edge fire (combinational from i_sig and history)
// -----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // NOTE: reset is sampled on the clock edge only, so it lives inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the program counter and instruction register. Executes the controller's
// LoadIR / IncPC / LoadPC / SelPC commands (edge-triggered), fetches over a
// req/ack memory port and reports valid, halt and timeout status.
//   clk, reset            clock; synchronous active-high reset
//   load_ir/inc_pc/load_pc level commands, acted on at their rising edge
//   sel_pc                load_pc source: 1 = imm_data, 0 = reg_data
//   reg_data/imm_data     jump targets
//   mem_req/mem_addr      read request (held until ack) and its address
//   mem_ack/mem_rdata     read data strobe and instruction word
//   opcode/ir_valid       IR contents and freshness flag
//   busy                  fetch in flight
//   pc                    program counter
//   halted/fetch_err      sticky HALT and timeout flags
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_ir,
    input  logic               inc_pc,
    input  logic               load_pc,
    input  logic               sel_pc,
    input  logic [ADDR_W-1:0]  reg_data,
    input  logic [ADDR_W-1:0]  imm_data,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] opcode,
    output logic               ir_valid,
    output logic               busy,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_ld_ir;
    logic w_inc;
    logic w_ld_pc;
    logic w_start;
    logic w_ack;
    logic w_tmo;

    rise_detect u_rd_load_ir (.clk(clk), .reset(reset), .i_sig(load_ir), .o_rise(w_ld_ir));
    rise_detect u_rd_inc_pc  (.clk(clk), .reset(reset), .i_sig(inc_pc),  .o_rise(w_inc));
    rise_detect u_rd_load_pc (.clk(clk), .reset(reset), .i_sig(load_pc), .o_rise(w_ld_pc));

    // mem_req is high exactly while in WAIT, so gating ack by state also
    // discards stray acks while no request is outstanding.
    assign w_start = (r_state == IDLE) && w_ld_ir && !halted;
    assign w_ack   = (r_state == WAIT) && mem_ack;
    // Ack on the timeout edge wins: the timeout term requires no ack.
    assign w_tmo   = (r_state == WAIT) && !mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

    assign busy = (r_state == WAIT);

    // FSM, memory request and timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            r_cnt     <= '0;
            fetch_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state  <= WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;   // pre-update PC if a PC command coincides
                        r_cnt    <= '0;
                    end
                end
                WAIT: begin
                    if (w_ack) begin
                        r_state <= IDLE;
                        mem_req <= 1'b0;
                    end else if (w_tmo) begin
                        r_state   <= ERR;
                        mem_req   <= 1'b0;
                        fetch_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                // NOTE: an explicit default keeps the case fully specified;
                // ERR simply holds every register.
                default: ;
            endcase
        end
    end

    // Instruction register and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode   <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            if (w_start) begin
                ir_valid <= 1'b0;
            end
            if (w_ack) begin
                opcode   <= mem_rdata;
                ir_valid <= 1'b1;
                if (is_halt(mem_rdata[INSTR_W-1 -: 4])) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    // Program counter: load beats increment; frozen in ERR and once halted
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (r_state != ERR && !halted) begin
            if (w_ld_pc) begin
                pc <= sel_pc ? imm_data : reg_data;
            end else if (w_inc) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. Inputs change and outputs are sampled
// on the falling clock edge; the design acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_ir, inc_pc, load_pc, sel_pc;
    logic [7:0] reg_data, imm_data;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] opcode;
    logic       ir_valid, busy;
    logic [7:0] pc;
    logic       halted, fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .sel_pc(sel_pc),
        .reg_data(reg_data), .imm_data(imm_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .opcode(opcode), .ir_valid(ir_valid), .busy(busy), .pc(pc),
        .halted(halted), .fetch_err(fetch_err)
    );

    task automatic do_reset;
        reset = 1'b1;
        load_ir = 1'b0; inc_pc = 1'b0; load_pc = 1'b0; sel_pc = 1'b0;
        reg_data = 8'h00; imm_data = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Raise the selected commands for one cycle, then hold them low for one.
    task automatic pulse(input logic li, input logic ii, input logic lp);
        load_ir = li; inc_pc = ii; load_pc = lp;
        @(negedge clk);
        load_ir = 1'b0; inc_pc = 1'b0; load_pc = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %h expected 00", pc); end
        n_cmp++; if (opcode !== 8'h00) begin n_bad++; $display("FAIL reset_opcode: got %h expected 00", opcode); end
        n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
        n_cmp++; if ({ir_valid, mem_req, busy, halted, fetch_err} !== 5'b00000) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 00000", {ir_valid, mem_req, busy, halted, fetch_err});
        end
    endtask

    task automatic test_basic_fetch;
        do_reset;
        load_ir = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mem_req, busy, ir_valid, mem_addr} !== {3'b110, 8'h00}) begin
            n_bad++; $display("FAIL fetch_req: got req/busy/valid/addr %b%b%b/%h expected 110/00", mem_req, busy, ir_valid, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 8'h45;
        @(negedge clk);
        mem_ack = 1'b0; load_ir = 1'b0;
        n_cmp++; if ({opcode, ir_valid, mem_req, busy} !== {8'h45, 3'b100}) begin
            n_bad++; $display("FAIL fetch_done: got op %h valid/req/busy %b%b%b expected 45 100", opcode, ir_valid, mem_req, busy);
        end
        // Wait-state fetch from pc=1 with three extra cycles
        pulse(1'b0, 1'b1, 1'b0);
        load_ir = 1'b1;
        @(negedge clk);
        load_ir = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({mem_req, ir_valid, mem_addr} !== {2'b10, 8'h01}) begin
            n_bad++; $display("FAIL fetch_wait: got req/valid %b%b addr %h expected 10 01", mem_req, ir_valid, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 8'h7E;
        @(negedge clk);
        mem_ack = 1'b0;
        n_cmp++; if ({opcode, ir_valid} !== {8'h7E, 1'b1}) begin
            n_bad++; $display("FAIL fetch_wait_done: got op %h valid %b expected 7e 1", opcode, ir_valid);
        end
        // Stray ack with no request outstanding is ignored
        mem_ack = 1'b1; mem_rdata = 8'h99;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if ({opcode, mem_req, busy} !== {8'h7E, 2'b00}) begin
            n_bad++; $display("FAIL stray_ack: got op %h req/busy %b%b expected 7e 00", opcode, mem_req, busy);
        end
    endtask

    task automatic test_pc_cmds;
        do_reset;
        repeat (3) pulse(1'b0, 1'b1, 1'b0);
        n_cmp++; if (pc !== 8'h03) begin n_bad++; $display("FAIL pc_inc3: got %h expected 03", pc); end
        sel_pc = 1'b1; imm_data = 8'hA0; reg_data = 8'h5C;
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++; if (pc !== 8'hA0) begin n_bad++; $display("FAIL pc_load_imm: got %h expected a0", pc); end
        sel_pc = 1'b0; reg_data = 8'h12;
        pulse(1'b0, 1'b1, 1'b1);
        n_cmp++; if (pc !== 8'h12) begin n_bad++; $display("FAIL pc_load_vs_inc: got %h expected 12", pc); end
        sel_pc = 1'b1; imm_data = 8'hFF;
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++; if (pc !== 8'hFF) begin n_bad++; $display("FAIL pc_load_ff: got %h expected ff", pc); end
        pulse(1'b0, 1'b1, 1'b0);
        n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL pc_wrap: got %h expected 00", pc); end
    endtask

    task automatic test_level_hold;
        int req_cycles;
        do_reset;
        req_cycles = 0;
        mem_ack = 1'b1; mem_rdata = 8'h33;
        load_ir = 1'b1; inc_pc = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (mem_req) req_cycles++;
        end
        load_ir = 1'b0; inc_pc = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_cycles !== 1) begin n_bad++; $display("FAIL hold_fetches: got %0d req cycles expected 1", req_cycles); end
        n_cmp++; if ({pc, mem_addr, opcode} !== {8'h01, 8'h00, 8'h33}) begin
            n_bad++; $display("FAIL hold_state: got pc %h addr %h op %h expected 01 00 33", pc, mem_addr, opcode);
        end
    endtask

    task automatic test_timeout;
        int req_cycles;
        do_reset;
        req_cycles = 0;
        load_ir = 1'b1;
        @(negedge clk);
        load_ir = 1'b0;
        for (int i = 0; i < 40 && !fetch_err; i++) begin
            if (mem_req) req_cycles++;
            @(negedge clk);
        end
        n_cmp++; if (req_cycles !== 15) begin n_bad++; $display("FAIL timeout_len: got %0d req cycles expected 15", req_cycles); end
        n_cmp++; if ({fetch_err, mem_req, busy} !== 3'b100) begin
            n_bad++; $display("FAIL timeout_err: got err/req/busy %b%b%b expected 100", fetch_err, mem_req, busy);
        end
        // ERR is terminal: fetch and increment commands do nothing
        load_ir = 1'b1; inc_pc = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mem_req, pc} !== {1'b0, 8'h00}) begin
            n_bad++; $display("FAIL err_ignores: got req %b pc %h expected 0 00", mem_req, pc);
        end
        load_ir = 1'b0; inc_pc = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout_ack;
        do_reset;
        load_ir = 1'b1;
        @(negedge clk);
        load_ir = 1'b0;
        repeat (14) @(negedge clk);
        n_cmp++; if ({mem_req, fetch_err} !== 2'b10) begin
            n_bad++; $display("FAIL timeout_early: got req/err %b%b expected 10", mem_req, fetch_err);
        end
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        @(negedge clk);
        mem_ack = 1'b0;
        n_cmp++; if ({fetch_err, ir_valid, mem_req, opcode} !== {3'b010, 8'h5A}) begin
            n_bad++; $display("FAIL timeout_ack: got err/valid/req %b%b%b op %h expected 010 5a", fetch_err, ir_valid, mem_req, opcode);
        end
    endtask

    task automatic test_halt;
        do_reset;
        // Low nibble F is not a halt
        load_ir = 1'b1; @(negedge clk); load_ir = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'hEF; @(negedge clk); mem_ack = 1'b0;
        n_cmp++; if ({halted, opcode} !== {1'b0, 8'hEF}) begin
            n_bad++; $display("FAIL not_halt: got halted %b op %h expected 0 ef", halted, opcode);
        end
        load_ir = 1'b1; @(negedge clk); load_ir = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'hF0; @(negedge clk); mem_ack = 1'b0;
        n_cmp++; if ({halted, opcode, ir_valid} !== {1'b1, 8'hF0, 1'b1}) begin
            n_bad++; $display("FAIL halt_set: got halted %b op %h valid %b expected 1 f0 1", halted, opcode, ir_valid);
        end
        pulse(1'b0, 1'b1, 1'b0);
        n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL halt_inc: got pc %h expected 00", pc); end
        load_ir = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mem_req, busy} !== 2'b00) begin
            n_bad++; $display("FAIL halt_fetch: got req/busy %b%b expected 00", mem_req, busy);
        end
        load_ir = 1'b0;
        @(negedge clk);
        sel_pc = 1'b1; imm_data = 8'h55;
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++; if ({pc, halted} !== {8'h00, 1'b1}) begin
            n_bad++; $display("FAIL halt_load: got pc %h halted %b expected 00 1", pc, halted);
        end
    endtask

    task automatic test_mid_fetch;
        do_reset;
        sel_pc = 1'b1; imm_data = 8'h20;
        pulse(1'b0, 1'b0, 1'b1);
        load_ir = 1'b1; @(negedge clk); load_ir = 1'b0;
        pulse(1'b0, 1'b1, 1'b0);
        n_cmp++; if ({mem_addr, pc, mem_req} !== {8'h20, 8'h21, 1'b1}) begin
            n_bad++; $display("FAIL mid_inc: got addr %h pc %h req %b expected 20 21 1", mem_addr, pc, mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 8'h11; @(negedge clk); mem_ack = 1'b0;
        n_cmp++; if ({opcode, ir_valid} !== {8'h11, 1'b1}) begin
            n_bad++; $display("FAIL mid_done: got op %h valid %b expected 11 1", opcode, ir_valid);
        end
        // Reset with a fetch in flight, inc_pc held high through reset
        load_ir = 1'b1; @(negedge clk); load_ir = 1'b0;
        @(negedge clk);
        reset = 1'b1; inc_pc = 1'b1;
        @(negedge clk);
        n_cmp++; if ({pc, opcode, mem_addr, ir_valid, mem_req, busy, halted, fetch_err} !== {24'h000000, 5'b00000}) begin
            n_bad++; $display("FAIL mid_reset: got pc %h op %h addr %h flags %b expected 00 00 00 00000",
                              pc, opcode, mem_addr, {ir_valid, mem_req, busy, halted, fetch_err});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (pc !== 8'h01) begin n_bad++; $display("FAIL held_cmd: got pc %h expected 01", pc); end
        inc_pc = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic_fetch;
        test_pc_cmds;
        test_level_hold;
        test_timeout;
        test_timeout_ack;
        test_halt;
        test_mid_fetch;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
